// File: rtl/fir_sm_fifo.sv
// Show-ahead output FIFO behind the FIR AXI-Stream master port. It buffers samples
// against consumer back-pressure, counts accepted samples and checks tlast placement.
module fir_sm_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH_LOG2 = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [31:0]            data_length,
  input  logic                   frame_clr,
  output logic [pDEPTH_LOG2:0]   level,
  output logic [31:0]            in_count,
  output logic                   tlast_err,
  output logic                   frame_done
);

  localparam int DEPTH = 1 << pDEPTH_LOG2;
  localparam int PW    = pDEPTH_LOG2 + 1;

  logic signed [pDATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]              mem_last;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          frame_end;
  logic [31:0]   cnt_base;
  logic [32:0]   cnt_plus;
  logic          len_match;
  logic          tlast_bad;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  assign s_tready = !full;
  assign m_tvalid = !empty;
  // Output is gated while empty so reset presents zeros despite unreset storage.
  assign m_tdata  = empty ? '0   : mem_data[rd_ptr[PW-2:0]];
  assign m_tlast  = empty ? 1'b0 : mem_last[rd_ptr[PW-2:0]];

  assign push = s_tvalid && s_tready;
  assign pop  = m_tvalid && m_tready;

  // A push after a tlast push opens a new frame, so counting restarts from zero.
  assign cnt_base  = frame_end ? 32'd0 : in_count;
  assign cnt_plus  = {1'b0, cnt_base} + 33'd1;
  assign len_match = (cnt_plus == {1'b0, data_length});
  assign tlast_bad = (s_tlast != len_match);

  // Storage stage: data path, not reset
  always_ff @(posedge axis_clk) begin
    if (push && !frame_clr) begin
      mem_data[wr_ptr[PW-2:0]] <= s_tdata;
      mem_last[wr_ptr[PW-2:0]] <= s_tlast;
    end
  end

  // Control stage: pointers, frame counter and sticky flags
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_count   <= '0;
      frame_end  <= 1'b0;
      tlast_err  <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_count   <= '0;
      frame_end  <= 1'b0;
      tlast_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        in_count  <= sat_inc(cnt_base);
        frame_end <= s_tlast;
        if (tlast_bad) tlast_err <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (m_tlast) frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Directed bench for fir_sm_fifo: a negedge monitor scoreboards every handshake
// and checks the AXI-Stream rules while the initial block drives directed steps.
module tb_fir_sm_fifo;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [31:0] data_length;
  logic        frame_clr;
  logic [4:0]  level;
  logic [31:0] in_count;
  logic        tlast_err;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic rand_rdy = 1'b0;
  logic [32:0] q[$];

  fir_sm_fifo #(.pDATA_WIDTH(32), .pDEPTH_LOG2(4)) dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .s_tvalid    (s_tvalid),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .data_length (data_length),
    .frame_clr   (frame_clr),
    .level       (level),
    .in_count    (in_count),
    .tlast_err   (tlast_err),
    .frame_done  (frame_done)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] gold(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic step();
    @(posedge axis_clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d, input logic l, output int waits);
    logic ok;
    logic done;
    done     = 1'b0;
    waits    = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int w = 0; w < 2000 && !done; w++) begin
      ok = s_tready;
      step();
      if (ok) done = 1'b1;
      else waits++;
    end
    s_tvalid = 1'b0;
    chk("send_timeout", 64'(done), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || level != 0) && n < 1000) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n < 1000), 64'(1));
  endtask

  task automatic clear_frame();
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
  endtask

  // Monitor: rule checks and scoreboard, sampled half a cycle from the active edge.
  logic        stall_prev = 1'b0;
  logic [32:0] stall_word = '0;
  always @(negedge axis_clk) begin
    logic [32:0] exp;
    if (!axis_rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("s_tready_rule", 64'(s_tready), 64'(level != 5'd16));
      chk("m_tvalid_rule", 64'(m_tvalid), 64'(level != 5'd0));
      chk("level_max", 64'(level <= 5'd16), 64'(1));
      if (stall_prev) begin
        chk("hold_valid", 64'(m_tvalid), 64'(1));
        chk("hold_word", 64'({m_tlast, m_tdata}), 64'(stall_word));
      end
      if (frame_clr) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (m_tvalid && m_tready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'(q.size()), 64'(1));
          end else begin
            exp = q.pop_front();
            chk("out_word", 64'({m_tlast, m_tdata}), 64'(exp));
          end
        end
        if (s_tvalid && s_tready) q.push_back({s_tlast, s_tdata});
        stall_prev = m_tvalid && !m_tready;
        stall_word = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    int w;
    int total;
    axis_rst_n  = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    m_tready    = 1'b0;
    data_length = 32'd0;
    frame_clr   = 1'b0;

    // Reset state
    #2;
    chk("rst_s_tready", 64'(s_tready), 64'(1));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_in_count", 64'(in_count), 64'(0));
    chk("rst_tlast_err", 64'(tlast_err), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    #10 axis_rst_n = 1'b1;
    step();

    // Pass-through of a 600-sample frame
    data_length = 32'd600;
    m_tready    = 1'b1;
    chk("pt_empty_valid", 64'(m_tvalid), 64'(0));
    send(gold(0), 1'b0, w);
    chk("pt_latency_valid", 64'(m_tvalid), 64'(1));
    chk("pt_latency_data", 64'(m_tdata), 64'(gold(0)));
    total = w;
    for (int i = 1; i < 600; i++) begin
      send(gold(i), (i == 599), w);
      total += w;
    end
    chk("pt_stall_cycles", 64'(total), 64'(0));
    drain();
    chk("pt_in_count", 64'(in_count), 64'(600));
    chk("pt_tlast_err", 64'(tlast_err), 64'(0));
    chk("pt_frame_done", 64'(frame_done), 64'(1));

    // Fill to full with the consumer stalled
    clear_frame();
    chk("clr_frame_done", 64'(frame_done), 64'(0));
    data_length = 32'd100;
    m_tready    = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send(32'(i), 1'b0, w);
      chk("fill_no_wait", 64'(w), 64'(0));
    end
    chk("full_level", 64'(level), 64'(16));
    chk("full_s_tready", 64'(s_tready), 64'(0));
    chk("full_head", 64'(m_tdata), 64'(1));
    s_tdata  = 32'd17;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (3) step();
    chk("held_level", 64'(level), 64'(16));
    chk("held_in_count", 64'(in_count), 64'(16));
    m_tready = 1'b1;
    chk("full_pop_s_tready", 64'(s_tready), 64'(0));
    for (int i = 17; i <= 20; i++) send(32'(i), 1'b0, w);
    drain();
    chk("fill_drained", 64'(level), 64'(0));
    chk("fill_in_count", 64'(in_count), 64'(20));

    // Random consumer ready across several pointer wraps
    clear_frame();
    data_length = 32'd1000;
    rand_rdy    = 1'b1;
    for (int i = 0; i < 100; i++) send(gold(1000 + i), 1'b0, w);
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    drain();
    chk("wrap_in_count", 64'(in_count), 64'(100));
    chk("wrap_tlast_err", 64'(tlast_err), 64'(0));

    // Missing tlast on the data_length-th sample
    clear_frame();
    data_length = 32'd11;
    for (int i = 1; i <= 10; i++) send(32'(i), 1'b0, w);
    chk("miss_err_before", 64'(tlast_err), 64'(0));
    send(32'd11, 1'b0, w);
    chk("miss_err", 64'(tlast_err), 64'(1));
    chk("miss_in_count", 64'(in_count), 64'(11));
    drain();
    chk("miss_frame_done", 64'(frame_done), 64'(0));

    // Early tlast on sample 10
    clear_frame();
    for (int i = 1; i <= 9; i++) send(32'(i), 1'b0, w);
    chk("early_err_before", 64'(tlast_err), 64'(0));
    send(32'd10, 1'b1, w);
    chk("early_err", 64'(tlast_err), 64'(1));
    chk("early_in_count", 64'(in_count), 64'(10));
    drain();
    chk("early_frame_done", 64'(frame_done), 64'(1));

    // Correct frame, then a new frame restarts counting at 1
    clear_frame();
    for (int i = 1; i <= 11; i++) send(32'(i), (i == 11), w);
    chk("good_err", 64'(tlast_err), 64'(0));
    chk("good_in_count", 64'(in_count), 64'(11));
    send(32'd12, 1'b0, w);
    chk("newframe_in_count", 64'(in_count), 64'(1));
    chk("newframe_err", 64'(tlast_err), 64'(0));
    send(32'd13, 1'b1, w);
    chk("short_frame_err", 64'(tlast_err), 64'(1));
    drain();
    chk("good_frame_done", 64'(frame_done), 64'(1));

    // frame_clr with five words queued, colliding with a push and a pop
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(gold(2000 + i), 1'b0, w);
    chk("pre_clr_level", 64'(level), 64'(5));
    chk("pre_clr_in_count", 64'(in_count), 64'(5));
    s_tdata   = 32'd99;
    s_tlast   = 1'b0;
    s_tvalid  = 1'b1;
    m_tready  = 1'b1;
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b0;
    chk("clr_level", 64'(level), 64'(0));
    chk("clr_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("clr_in_count", 64'(in_count), 64'(0));
    chk("clr_tlast_err", 64'(tlast_err), 64'(0));
    chk("clr_frame_done", 64'(frame_done), 64'(0));

    // Asynchronous reset mid-frame, between clock edges
    data_length = 32'd4;
    for (int i = 0; i < 3; i++) send(gold(3000 + i), 1'b0, w);
    chk("pre_rst_level", 64'(level), 64'(3));
    #3;
    axis_rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("arst_s_tready", 64'(s_tready), 64'(1));
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_in_count", 64'(in_count), 64'(0));
    chk("arst_m_tdata", 64'(m_tdata), 64'(0));
    repeat (2) @(posedge axis_clk);
    #3 axis_rst_n = 1'b1;
    step();
    chk("post_rst_level", 64'(level), 64'(0));
    m_tready    = 1'b1;
    data_length = 32'd1;
    send(gold(4000), 1'b1, w);
    chk("post_rst_in_count", 64'(in_count), 64'(1));
    drain();
    chk("post_rst_err", 64'(tlast_err), 64'(0));
    chk("post_rst_done", 64'(frame_done), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
